// File: rtl/flsub_pkg.sv
// Shared constants for the flsub subtractor: default width and borrow statistics counter sizing.
package flsub_pkg;
    localparam int FLSUB_DEFAULT_WIDTH = 1;
    localparam int FLSUB_CNT_W         = 16;
    localparam logic [FLSUB_CNT_W-1:0] FLSUB_CNT_MAX = {FLSUB_CNT_W{1'b1}};
endpackage

// File: rtl/flsub_cell.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the bit borrows.
// Purely combinational, zero latency, no backpressure.
module flsub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/flsub.sv
// Ripple-borrow subtractor d = a - b - c with a registered copy (1-cycle latency, gated by en, no backpressure).
// Optional FLSUB_STATS_EN adds a saturating count of captured borrows on borrow_cnt.
module flsub
    import flsub_pkg::*;
#(
    parameter int WIDTH = FLSUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             en,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic [WIDTH-1:0] d_q,
    output logic             bo_q,
    output logic             vld_q
`ifdef FLSUB_STATS_EN
    ,
    output logic [FLSUB_CNT_W-1:0] borrow_cnt
`endif
);
    logic [WIDTH:0] br;

    assign br[0] = c;
    assign bo    = br[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        flsub_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (br[i]),
            .d    (d[i]),
            .bout (br[i+1])
        );
    end

    // Result registers hold when idle; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q   <= '0;
            bo_q  <= 1'b0;
            vld_q <= 1'b0;
        end else if (en) begin
            d_q   <= d;
            bo_q  <= bo;
            vld_q <= 1'b1;
        end else begin
            vld_q <= 1'b0;
        end
    end

`ifdef FLSUB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            borrow_cnt <= '0;
        end else if (en && bo && (borrow_cnt != FLSUB_CNT_MAX)) begin
            borrow_cnt <= borrow_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_flsub.sv
// Self-checking bench for flsub at WIDTH=1 and WIDTH=8: vector tables, corner sequences, random vs. arithmetic model.
module tb_flsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, c;
    logic       a1, b1;
    logic [7:0] a8, b8;
    logic       d1, bo1, d1_q, bo1_q, vld1_q;
    logic [7:0] d8, d8_q;
    logic       bo8, bo8_q, vld8_q;
`ifdef FLSUB_STATS_EN
    logic [15:0] cnt1, cnt8;
`endif

    flsub #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c), .en(en),
        .d(d1), .bo(bo1), .d_q(d1_q), .bo_q(bo1_q), .vld_q(vld1_q)
`ifdef FLSUB_STATS_EN
        , .borrow_cnt(cnt1)
`endif
    );

    flsub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c), .en(en),
        .d(d8), .bo(bo8), .d_q(d8_q), .bo_q(bo8_q), .vld_q(vld8_q)
`ifdef FLSUB_STATS_EN
        , .borrow_cnt(cnt8)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t v1[8];
    vec_t v8[2];

    logic [7:0] md;
    logic       mbo, mv;
    logic [7:0] ed;
    logic       ebo;
    int         diff;
`ifdef FLSUB_STATS_EN
    int         mcnt;
`endif

    initial begin
        // WIDTH=1 truth table in (a,b,c) order 000..111
        v1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0};
        v1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b1};
        v1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b1};
        v1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1};
        v1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0};
        v1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b0};
        v1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b0};
        v1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1};
        v8[0] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        v8[1] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};

        rst = 1'b1; en = 1'b0; c = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_d1_q", 16'(d1_q), 16'h0);
        check("rst_bo1_q", 16'(bo1_q), 16'h0);
        check("rst_vld1_q", 16'(vld1_q), 16'h0);
        check("rst_d8_q", 16'(d8_q), 16'h0);
        check("rst_vld8_q", 16'(vld8_q), 16'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            a1 = v1[i].a[0]; b1 = v1[i].b[0]; c = v1[i].c;
            #1;
            check($sformatf("w1_d[%0d]", i), 16'(d1), 16'(v1[i].d[0]));
            check($sformatf("w1_bo[%0d]", i), 16'(bo1), 16'(v1[i].bo));
        end
        for (int i = 0; i < 2; i++) begin
            a8 = v8[i].a; b8 = v8[i].b; c = v8[i].c;
            #1;
            check($sformatf("w8_d[%0d]", i), 16'(d8), 16'(v8[i].d));
            check($sformatf("w8_bo[%0d]", i), 16'(bo8), 16'(v8[i].bo));
        end

        // Capture then hold
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b0; c = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        check("cap_d_q", 16'(d1_q), 16'h1);
        check("cap_bo_q", 16'(bo1_q), 16'h1);
        check("cap_vld_q", 16'(vld1_q), 16'h1);
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; c = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        check("hold_d_q", 16'(d1_q), 16'h1);
        check("hold_bo_q", 16'(bo1_q), 16'h1);
        check("hold_vld_q", 16'(vld1_q), 16'h0);

        // Reset wins over enable; combinational path unaffected
        @(negedge clk);
        rst = 1'b1; en = 1'b1; a1 = 1'b0; b1 = 1'b1; c = 1'b0;
        #1;
        check("rst_en_d_pre", 16'(d1), 16'h1);
        @(posedge clk); #1;
        check("rst_en_d_q", 16'(d1_q), 16'h0);
        check("rst_en_bo_q", 16'(bo1_q), 16'h0);
        check("rst_en_vld_q", 16'(vld1_q), 16'h0);
        check("rst_en_d", 16'(d1), 16'h1);
        check("rst_en_bo", 16'(bo1), 16'h1);

        md = 8'h00; mbo = 1'b0; mv = 1'b0;
`ifdef FLSUB_STATS_EN
        mcnt = 0;
        check("rst_cnt8", cnt8, 16'h0);
`endif
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            c   = 1'($urandom);
            en  = 1'($urandom);
            rst = ($urandom_range(0, 15) == 0);
            #1;
            diff = int'(a8) - int'(b8) - int'(c);
            ed   = 8'(diff & 255);
            ebo  = (diff < 0);
            check("rnd_d", 16'(d8), 16'(ed));
            check("rnd_bo", 16'(bo8), 16'(ebo));
            if (rst) begin
                md = 8'h00; mbo = 1'b0; mv = 1'b0;
`ifdef FLSUB_STATS_EN
                mcnt = 0;
`endif
            end else if (en) begin
                md = ed; mbo = ebo; mv = 1'b1;
`ifdef FLSUB_STATS_EN
                if (ebo && mcnt < 65535) mcnt++;
`endif
            end else begin
                mv = 1'b0;
            end
            @(posedge clk); #1;
            check("rnd_d_q", 16'(d8_q), 16'(md));
            check("rnd_bo_q", 16'(bo8_q), 16'(mbo));
            check("rnd_vld_q", 16'(vld8_q), 16'(mv));
`ifdef FLSUB_STATS_EN
            check("rnd_cnt", cnt8, 16'(mcnt));
`endif
        end

`ifdef FLSUB_STATS_EN
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        rst = 1'b0; en = 1'b1; a8 = 8'h00; b8 = 8'h01; c = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("cnt_three", cnt8, 16'd3);
        for (int i = 0; i < 65532; i++) @(negedge clk);
        check("cnt_max", cnt8, 16'hFFFF);
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("cnt_sat", cnt8, 16'hFFFF);
        rst = 1'b1;
        @(negedge clk);
        check("cnt_rst", cnt8, 16'h0);
        rst = 1'b0; en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
